// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, RX capture FSM encoding and default RX FIFO depth
package uart_pkg;
    localparam int DATA_BITS     = 8;
    localparam int STOP_BITS     = 1;
    localparam int OVERSAMPLE    = 16;
    localparam int RX_FIFO_DEPTH = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        GUARD = 2'd2
    } rx_cap_state_t;
endpackage

// File: rtl/rx_byte_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through byte FIFO
//   clk, rst      : clock, async active-high reset (pointers and count only)
//   push, wdata   : write request and byte; ignored when full
//   pop           : read request; ignored when empty
//   rdata         : head entry, read combinationally from storage
//   count         : stored entries 0..DEPTH
//   full, empty   : derived from count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    // storage has no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: captures bytes from an 8N1 receiver handshake into a FWFT FIFO
//   clk, rst             : clock, async active-high reset
//   rx_done, rx_byte     : level byte-ready flag and byte from the receiver
//   rx_read              : one-cycle registered acknowledge back to the receiver
//   out_data, out_valid  : FIFO head and non-empty flag
//   out_ready            : consumer accept
//   count                : stored bytes
//   overflow, ovf_clear  : sticky drop flag and its synchronous clear
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_done,
    input  logic [7:0]    rx_byte,
    output logic          rx_read,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          ovf_clear
);
    rx_cap_state_t state, state_n;
    logic capture, full, empty;
    // GUARD holds until rx_done drops so a held flag is never captured twice
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (rx_done ? ACK : IDLE) :
                  (state == ACK)  ? GUARD :
                  (rx_done ? GUARD : IDLE);
    end
    assign capture   = (state == IDLE) && rx_done;
    assign out_valid = !empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_read  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            rx_read  <= state_n == ACK;
            // a drop in the same cycle as a clear keeps the flag set
            overflow <= (capture && full) ? 1'b1 : ovf_clear ? 1'b0 : overflow;
        end
    end
    sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (out_ready),
        .wdata (rx_byte),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed table and sequence checks for rx_byte_fifo
module tb_rx_byte_fifo;
    import uart_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clear = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] popped [$];

    rx_byte_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .rx_read   (rx_read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic [7:0] b;
        logic       rdy;
        logic       clr;
        logic       e_ack;
        int         e_cnt;
        logic       e_val;
        logic [7:0] e_dat;
        logic       e_ovf;
    } vec_t;
    vec_t v [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (out_valid && out_ready) popped.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_done = 1'b0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // one full receiver handshake: capture, ack, receiver clears, guard exits
    task automatic send(input logic [7:0] b, input logic rdy, input logic clr);
        rx_done = 1'b1;
        rx_byte = b;
        out_ready = rdy;
        ovf_clear = clr;
        tick();
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        chk("send_ack", {31'b0, rx_read}, 32'd1);
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    initial begin
        v[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'hA5, 1'b0};
        v[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
        v[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
        v[3]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h5A, 1'b0};
        v[4]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
        v[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        v[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        v[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h77, 1'b0};
        v[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h77, 1'b0};
        v[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h77, 1'b0};
        v[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};

        do_reset();
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_rx_read", {31'b0, rx_read}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            rx_done = v[i].rd;
            rx_byte = v[i].b;
            out_ready = v[i].rdy;
            ovf_clear = v[i].clr;
            tick();
            chk($sformatf("vec%0d_rx_read", i), {31'b0, rx_read}, {31'b0, v[i].e_ack});
            chk($sformatf("vec%0d_count", i), {27'b0, count}, v[i].e_cnt);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, v[i].e_val});
            if (v[i].e_val) chk($sformatf("vec%0d_data", i), {24'b0, out_data}, {24'b0, v[i].e_dat});
            chk($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, v[i].e_ovf});
        end
        out_ready = 1'b0;
        rx_done = 1'b0;

        // order and pointer wrap with one pop per handshake
        do_reset();
        popped.delete();
        for (int i = 0; i < 20; i++) send(8'(i), 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("order_len", popped.size(), 32'd20);
        for (int i = 0; i < 20 && i < popped.size(); i++)
            chk($sformatf("order_byte%0d", i), {24'b0, popped[i]}, i);
        chk("order_ovf", {31'b0, overflow}, 32'd0);
        chk("order_count", {27'b0, count}, 32'd0);

        // overflow, clear, and set-beats-clear
        do_reset();
        for (int i = 0; i < 17; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
        chk("ovf_count16", {27'b0, count}, 32'd16);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);
        send(8'hEE, 1'b0, 1'b1);
        chk("ovf_set_wins", {31'b0, overflow}, 32'd1);
        chk("ovf_count_still16", {27'b0, count}, 32'd16);
        popped.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        out_ready = 1'b0;
        chk("ovf_drain_len", popped.size(), 32'd16);
        for (int i = 0; i < 16 && i < popped.size(); i++)
            chk($sformatf("ovf_byte%0d", i), {24'b0, popped[i]}, 32'h40 + i);
        chk("ovf_drain_count", {27'b0, count}, 32'd0);

        // simultaneous push/pop at count 5 and at full
        do_reset();
        for (int i = 0; i < 5; i++) send(8'(i), 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        chk("pp_count5", {27'b0, count}, 32'd5);
        for (int i = 0; i < 11; i++) send(8'(i), 1'b0, 1'b0);
        chk("pp_full", {27'b0, count}, 32'd16);
        chk("pp_full_noovf", {31'b0, overflow}, 32'd0);
        send(8'h66, 1'b1, 1'b0);
        chk("pp_full_count15", {27'b0, count}, 32'd15);
        chk("pp_full_ovf", {31'b0, overflow}, 32'd1);

        // rx_done stuck high after the acknowledge
        do_reset();
        rx_done = 1'b1;
        rx_byte = 8'h11;
        tick();
        chk("stuck_ack", {31'b0, rx_read}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            rx_byte = 8'h20 + 8'(i);
            tick();
            chk($sformatf("stuck_rx_read%0d", i), {31'b0, rx_read}, 32'd0);
            chk($sformatf("stuck_count%0d", i), {27'b0, count}, 32'd1);
        end
        chk("stuck_guard", {30'b0, dut.state}, {30'b0, GUARD});
        rx_done = 1'b0;
        tick();
        chk("stuck_idle", {30'b0, dut.state}, {30'b0, IDLE});
        rx_done = 1'b1;
        rx_byte = 8'h22;
        tick();
        chk("stuck_next_ack", {31'b0, rx_read}, 32'd1);
        chk("stuck_next_count", {27'b0, count}, 32'd2);
        chk("stuck_head", {24'b0, out_data}, 32'h11);
        tick();
        rx_done = 1'b0;
        tick();

        // asynchronous reset while in ACK
        do_reset();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        rx_done = 1'b1;
        rx_byte = 8'h99;
        tick();
        chk("rack_ack", {31'b0, rx_read}, 32'd1);
        chk("rack_count3", {27'b0, count}, 32'd3);
        #2 rst = 1'b1;
        rx_byte = 8'h3C;
        #1;
        chk("rack_count0", {27'b0, count}, 32'd0);
        chk("rack_valid0", {31'b0, out_valid}, 32'd0);
        chk("rack_rx_read0", {31'b0, rx_read}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rack_cap_ack", {31'b0, rx_read}, 32'd1);
        chk("rack_cap_count", {27'b0, count}, 32'd1);
        chk("rack_cap_data", {24'b0, out_data}, 32'h3C);
        tick();
        rx_done = 1'b0;
        tick();
        tick();
        chk("rack_single", {27'b0, count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
